// File: rtl/fetch_unit_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } t_fetch_entry;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus bundle: instruction memory request/response, redirect, and decode handshake.
interface fetch_unit_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_plus4;

  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_pc_plus4,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc, dec_pc_plus4,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, dec_ready
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Synchronous power-of-two FIFO with flush; push into a full FIFO is only legal alongside a pop.
module fetch_unit_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = logic [31:0]
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  T                         push_data,
  output T                         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign count   = cnt_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited in-order imem reads, PC-tagged instruction queue, redirect flush.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] inflight_cnt_q, inflight_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic          req_valid, accept, rsp_drop, rsp_keep, tag_pop, dec_valid, dec_pop;
  logic [31:0]   tag_pc;
  logic          tag_full, tag_empty;
  logic [CW-1:0] tag_count;
  t_fetch_entry  q_head, q_push_data;
  logic          q_full, q_empty;
  logic [CW-1:0] q_count;
  logic          unused_status;

  // Credit: every outstanding request already owns a queue slot.
  assign req_valid = !rst && ((SW'(inflight_cnt_q) + SW'(q_count)) < SW'(FIFO_DEPTH));
  assign accept    = req_valid && bus.imem_req_ready;
  assign rsp_drop  = bus.imem_rsp_valid && (drop_cnt_q != '0);
  assign rsp_keep  = bus.imem_rsp_valid && (drop_cnt_q == '0) && !bus.redirect_valid;
  assign tag_pop   = bus.imem_rsp_valid && (drop_cnt_q == '0);
  assign dec_valid = !rst && !q_empty;
  assign dec_pop   = dec_valid && bus.dec_ready;

  assign q_push_data = '{pc: tag_pc, instr: bus.imem_rsp_data};

  always_comb begin
    pc_d           = pc_q;
    drop_cnt_d     = drop_cnt_q;
    inflight_cnt_d = inflight_cnt_q + CW'(accept) - CW'(bus.imem_rsp_valid);
    if (accept)   pc_d       = pc_q + 32'd4;
    if (rsp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
    // Everything still outstanding after this cycle belongs to the old stream.
    if (bus.redirect_valid) begin
      pc_d       = align_pc(bus.redirect_pc);
      drop_cnt_d = inflight_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      inflight_cnt_q <= '0;
      drop_cnt_q     <= '0;
    end else begin
      pc_q           <= pc_d;
      inflight_cnt_q <= inflight_cnt_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  fetch_unit_fifo #(.DEPTH(FIFO_DEPTH), .T(logic [31:0])) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .pop       (tag_pop),
    .flush     (bus.redirect_valid),
    .push_data (pc_q),
    .head      (tag_pc),
    .full      (tag_full),
    .empty     (tag_empty),
    .count     (tag_count)
  );

  fetch_unit_fifo #(.DEPTH(FIFO_DEPTH), .T(t_fetch_entry)) u_instr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_keep),
    .pop       (dec_pop),
    .flush     (bus.redirect_valid),
    .push_data (q_push_data),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign unused_status = ^{tag_full, tag_empty, tag_count, q_full};

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.dec_valid      = dec_valid;
  assign bus.dec_instr      = q_head.instr;
  assign bus.dec_pc         = q_head.pc;
  assign bus.dec_pc_plus4   = q_head.pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order imem model returning the address as data, decode capture.
module tb_fetch_unit;

  localparam int unsigned FD = 4;

  logic clk;
  logic rst;
  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(FD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [31:0] mq[$];
  int          mdue[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_in[$];
  logic [31:0] got_p4[$];
  int          got_cyc[$];

  bit   rand_ready = 0, rand_dec = 0, rand_lat = 0, chk_flow = 0;
  int   fixed_lat = 1;
  int   n_acc = 0, n_pop = 0;
  logic stall_prev = 1'b0;
  logic [31:0] stall_addr = '0;
  logic obs_req_valid, obs_dec_valid, obs_rsp, obs_hs;
  logic [31:0] obs_addr, obs_dec_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] gq(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hBAD0_BAD0;
  endfunction

  // One clock: present imem response, sample just after the inputs settle, then advance.
  task automatic tick();
    int lat;
    int d;
    if (rst) begin
      mq.delete();
      mdue.delete();
    end
    if (mq.size() > 0 && mdue[0] == cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mq.pop_front();
      void'(mdue.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
    end
    if (rand_ready) bus.imem_req_ready = 1'($urandom_range(0, 1));
    if (rand_dec)   bus.dec_ready      = 1'($urandom_range(0, 1));
    #1;
    obs_req_valid = bus.imem_req_valid;
    obs_dec_valid = bus.dec_valid;
    obs_addr      = bus.imem_req_addr;
    obs_dec_pc    = bus.dec_pc;
    obs_rsp       = bus.imem_rsp_valid;
    obs_hs        = bus.dec_valid && bus.dec_ready;
    if (chk_flow) begin
      if (stall_prev) begin
        chk("t5 addr hold", bus.imem_req_addr, stall_addr);
        chk("t5 valid hold", 32'(bus.imem_req_valid), 32'd1);
      end
      chk("t5 credit", 32'(bus.imem_req_valid), 32'((n_acc - n_pop) < int'(FD)));
    end
    stall_prev = !rst && bus.imem_req_valid && !bus.imem_req_ready;
    stall_addr = bus.imem_req_addr;
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      lat = rand_lat ? int'($urandom_range(1, 3)) : fixed_lat;
      d   = cyc + lat;
      if (mdue.size() > 0 && d <= mdue[mdue.size()-1]) d = mdue[mdue.size()-1] + 1;
      mq.push_back(bus.imem_req_addr);
      mdue.push_back(d);
      n_acc++;
    end
    if (obs_hs) begin
      got_pc.push_back(bus.dec_pc);
      got_in.push_back(bus.dec_instr);
      got_p4.push_back(bus.dec_pc_plus4);
      got_cyc.push_back(cyc);
      n_pop++;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_got();
    got_pc.delete();
    got_in.delete();
    got_p4.delete();
    got_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("reset req_valid", 32'(obs_req_valid), 32'd0);
      chk("reset dec_valid", 32'(obs_dec_valid), 32'd0);
    end
    rst = 1'b0;
    n_acc = 0;
    n_pop = 0;
    clear_got();
  endtask

  initial begin
    int base;
    rst                = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.dec_ready      = 1'b1;
    @(negedge clk);

    // 1: streaming from reset, 1-cycle imem
    do_reset();
    base = cyc;
    tick();
    chk("t1 first req_valid", 32'(obs_req_valid), 32'd1);
    chk("t1 first addr", obs_addr, 32'h0);
    chk("t1 c0 dec_valid", 32'(obs_dec_valid), 32'd0);
    for (int i = 0; i < 9; i++) tick();
    for (int i = 0; i < 6; i++) begin
      chk("t1 dec_pc", gq(got_pc, i), 32'(4 * i));
      chk("t1 dec_instr", gq(got_in, i), 32'(4 * i));
      chk("t1 pc_plus4", gq(got_p4, i), 32'(4 * i + 4));
      chk("t1 dec cycle", 32'((i < got_cyc.size()) ? got_cyc[i] : -1), 32'(base + 2 + i));
    end

    // 2: decoder stalled, fetch fills exactly FIFO_DEPTH then stops
    do_reset();
    bus.dec_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("t2 accepted", 32'(n_acc), 32'(FD));
    chk("t2 req_valid off", 32'(obs_req_valid), 32'd0);
    chk("t2 head valid", 32'(obs_dec_valid), 32'd1);
    chk("t2 head pc", obs_dec_pc, 32'h0);
    chk("t2 no pops", 32'(got_pc.size()), 32'd0);
    bus.dec_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    for (int i = 0; i < 8; i++) chk("t2 order", gq(got_pc, i), 32'(4 * i));

    // 3: redirect with two requests in flight (3-cycle imem)
    do_reset();
    fixed_lat = 3;
    tick();
    tick();
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0100;
    tick();
    bus.redirect_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    tick();
    chk("t3 new addr", obs_addr, 32'h0000_0100);
    for (int i = 0; i < 11; i++) tick();
    chk("t3 first pc", gq(got_pc, 0), 32'h0000_0100);
    chk("t3 first instr", gq(got_in, 0), 32'h0000_0100);
    chk("t3 second pc", gq(got_pc, 1), 32'h0000_0104);
    fixed_lat = 1;

    // 4: redirect coincident with imem response and decode pop
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    tick();
    chk("t4 hs at redirect", 32'(obs_hs), 32'd1);
    chk("t4 rsp at redirect", 32'(obs_rsp), 32'd1);
    chk("t4 popped pc", obs_dec_pc, 32'h4);
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("t4 pc0", gq(got_pc, 0), 32'h0);
    chk("t4 pc1", gq(got_pc, 1), 32'h4);
    chk("t4 pc2", gq(got_pc, 2), 32'h0000_0200);
    chk("t4 pc3", gq(got_pc, 3), 32'h0000_0204);

    // 5: random imem ready, latency 1-3, random decode ready
    do_reset();
    rand_ready = 1;
    rand_dec   = 1;
    rand_lat   = 1;
    chk_flow   = 1;
    for (int i = 0; i < 300; i++) tick();
    chk_flow   = 0;
    rand_ready = 0;
    rand_dec   = 0;
    rand_lat   = 0;
    bus.imem_req_ready = 1'b1;
    bus.dec_ready      = 1'b1;
    chk("t5 progress", 32'(got_pc.size() > 20), 32'd1);
    for (int i = 0; i < got_pc.size(); i++) begin
      chk("t5 pc seq", got_pc[i], 32'(4 * i));
      chk("t5 instr", got_in[i], 32'(4 * i));
    end

    // 6: PC wrap and misaligned redirect target
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF8;
    tick();
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("t6 pc0", gq(got_pc, 0), 32'hFFFF_FFF8);
    chk("t6 pc1", gq(got_pc, 1), 32'hFFFF_FFFC);
    chk("t6 pc2", gq(got_pc, 2), 32'h0000_0000);
    chk("t6 plus4 wrap", gq(got_p4, 1), 32'h0000_0000);
    chk("t6 instr0", gq(got_in, 0), 32'hFFFF_FFF8);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    tick();
    bus.redirect_valid = 1'b0;
    clear_got();
    for (int i = 0; i < 8; i++) tick();
    chk("t6 aligned pc", gq(got_pc, 0), 32'h0000_0100);
    chk("t6 aligned instr", gq(got_in, 0), 32'h0000_0100);
    chk("t6 next pc", gq(got_pc, 1), 32'h0000_0104);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
